// File: rtl/mul_bus_master_if.sv
// Request/grant bus between mul_bus_master and the memory-mapped multiplier slave.
interface mul_bus_master_if;
    logic        M_req;
    logic        M_grant;
    logic        M_sel;
    logic        M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout;
    logic [31:0] M_din;

    modport master (
        output M_req, M_sel, M_wr, M_address, M_dout,
        input  M_grant, M_din
    );

    modport slave (
        input  M_req, M_sel, M_wr, M_address, M_dout,
        output M_grant, M_din
    );
endinterface

// File: rtl/mul_bus_master.sv
// Drives a memory-mapped 64x64 multiplier: write operands, start, wait, read product, clear.
// Build macro MUL_MASTER_IRQ_EN: wait for m_interrupt instead of polling the status register.
module mul_bus_master (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      cmd_a,
    input  logic [63:0]      cmd_b,
    output logic             rsp_valid,
    output logic [127:0]     rsp_result,
    output logic             rsp_err,
    mul_bus_master_if.master bus,
    input  logic             m_interrupt
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_REQ   = 4'd1;
    localparam logic [3:0] S_IE    = 4'd2;
    localparam logic [3:0] S_OP0   = 4'd3;
    localparam logic [3:0] S_OP1   = 4'd4;
    localparam logic [3:0] S_OP2   = 4'd5;
    localparam logic [3:0] S_OP3   = 4'd6;
    localparam logic [3:0] S_START = 4'd7;
    localparam logic [3:0] S_WAIT  = 4'd8;
    localparam logic [3:0] S_RD0   = 4'd9;
    localparam logic [3:0] S_RD1   = 4'd10;
    localparam logic [3:0] S_RD2   = 4'd11;
    localparam logic [3:0] S_RD3   = 4'd12;
    localparam logic [3:0] S_CLR1  = 4'd13;
    localparam logic [3:0] S_STOP  = 4'd14;
    localparam logic [3:0] S_CLR0  = 4'd15;

`ifdef MUL_MASTER_IRQ_EN
    localparam logic IRQ_VAL = 1'b1;
`else
    localparam logic IRQ_VAL = 1'b0;
    logic irq_unused;
    assign irq_unused = m_interrupt;
`endif

    logic [3:0]  state;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [15:0] tmo;
    logic [15:0] tmo_next;
    logic        rd_cnt;
    logic        acc_active;
    logic        acc_wr;
    logic [7:0]  acc_addr;
    logic [31:0] acc_data;
    logic        rd_done;
    logic        acc_done;

    // Access currently owed by each state; it is held on the bus while grant is low.
    always_comb begin
        acc_active = 1'b0;
        acc_wr     = 1'b0;
        acc_addr   = '0;
        acc_data   = '0;
        case (state)
            S_IE:    begin acc_active = 1'b1; acc_wr = 1'b1; acc_addr = 8'h08; acc_data = {31'd0, IRQ_VAL}; end
            S_OP0:   begin acc_active = 1'b1; acc_wr = 1'b1; acc_addr = 8'h00; acc_data = op_a[31:0];  end
            S_OP1:   begin acc_active = 1'b1; acc_wr = 1'b1; acc_addr = 8'h01; acc_data = op_a[63:32]; end
            S_OP2:   begin acc_active = 1'b1; acc_wr = 1'b1; acc_addr = 8'h02; acc_data = op_b[31:0];  end
            S_OP3:   begin acc_active = 1'b1; acc_wr = 1'b1; acc_addr = 8'h03; acc_data = op_b[63:32]; end
            S_START: begin acc_active = 1'b1; acc_wr = 1'b1; acc_addr = 8'h0A; acc_data = 32'd1; end
`ifdef MUL_MASTER_IRQ_EN
            S_WAIT:  ;
`else
            S_WAIT:  begin acc_active = 1'b1; acc_addr = 8'h09; end
`endif
            S_RD0:   begin acc_active = 1'b1; acc_addr = 8'h04; end
            S_RD1:   begin acc_active = 1'b1; acc_addr = 8'h05; end
            S_RD2:   begin acc_active = 1'b1; acc_addr = 8'h06; end
            S_RD3:   begin acc_active = 1'b1; acc_addr = 8'h07; end
            S_CLR1:  begin acc_active = 1'b1; acc_wr = 1'b1; acc_addr = 8'h0B; acc_data = 32'd1; end
            S_STOP:  begin acc_active = 1'b1; acc_wr = 1'b1; acc_addr = 8'h0A; end
            S_CLR0:  begin acc_active = 1'b1; acc_wr = 1'b1; acc_addr = 8'h0B; end
            default: ;
        endcase
    end

    assign rd_done  = acc_active && !acc_wr && bus.M_grant && rd_cnt;
    assign acc_done = (acc_active && acc_wr && bus.M_grant) || rd_done;
    assign tmo_next = tmo + 16'd1;

    assign cmd_ready     = reset_n && (state == S_IDLE) && !rsp_valid;
    assign bus.M_req     = (state != S_IDLE);
    assign bus.M_sel     = acc_active && bus.M_grant;
    assign bus.M_wr      = acc_active && acc_wr;
    assign bus.M_address = acc_addr;
    assign bus.M_dout    = acc_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            tmo        <= '0;
            rd_cnt     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            // A read needs two consecutive granted cycles; a grant gap restarts the count.
            rd_cnt    <= acc_active && !acc_wr && bus.M_grant && !rd_cnt;

            if (rd_done) begin
                case (state)
                    S_RD0:   rsp_result[31:0]   <= bus.M_din;
                    S_RD1:   rsp_result[63:32]  <= bus.M_din;
                    S_RD2:   rsp_result[95:64]  <= bus.M_din;
                    S_RD3:   rsp_result[127:96] <= bus.M_din;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_a       <= cmd_a;
                        op_b       <= cmd_b;
                        tmo        <= '0;
                        rsp_err    <= 1'b0;
                        rsp_result <= '0;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.M_grant) state <= S_IE;
                end
                S_WAIT: begin
                    tmo <= tmo_next;
                    if (tmo_next == 16'hFFFF) begin
                        rsp_err <= 1'b1;
                        state   <= S_CLR1;
                    end
`ifdef MUL_MASTER_IRQ_EN
                    else if (m_interrupt) state <= S_RD0;
`else
                    else if (rd_done && bus.M_din[1:0] == 2'b01) state <= S_RD0;
`endif
                end
                S_CLR0: begin
                    if (acc_done) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    if (acc_done) state <= state + 4'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_bus_master.sv
// Self-checking bench for mul_bus_master with a registered multiplier slave model and a response scoreboard.
`timescale 1ns/1ps
module tb_mul_bus_master;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [63:0]  cmd_a;
    logic [63:0]  cmd_b;
    logic         rsp_valid;
    logic [127:0] rsp_result;
    logic         rsp_err;
    logic         m_interrupt;

    mul_bus_master_if bus();

    mul_bus_master dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .bus        (bus),
        .m_interrupt(m_interrupt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Grant generator: changes shortly after the rising edge so the DUT sees it settled.
    int grant_mode = 0;
    int gtick = 0;
    initial bus.M_grant = 1'b1;
    always @(posedge clk) begin
        #2;
        gtick++;
        bus.M_grant = (grant_mode == 0) ? 1'b1 : gtick[1];
    end

    // Slave model: operand registers, registered read data, status DONE after done_after poll cycles.
    logic [31:0]  sregs [4];
    int unsigned  st_cnt = 0;
    int unsigned  done_after = 4;
    logic [127:0] sprod;
    assign sprod = {64'd0, sregs[1], sregs[0]} * {64'd0, sregs[3], sregs[2]};

    initial begin
        bus.M_din = '0;
        for (int i = 0; i < 4; i++) sregs[i] = '0;
    end

    always @(posedge clk) begin
        if (bus.M_sel) begin
            if (bus.M_wr) begin
                if (bus.M_address < 8'h04) sregs[bus.M_address[1:0]] <= bus.M_dout;
                if (bus.M_address == 8'h0A && bus.M_dout[0]) st_cnt <= 0;
            end else begin
                case (bus.M_address)
                    8'h04: bus.M_din <= sprod[31:0];
                    8'h05: bus.M_din <= sprod[63:32];
                    8'h06: bus.M_din <= sprod[95:64];
                    8'h07: bus.M_din <= sprod[127:96];
                    8'h09: begin
                        bus.M_din <= (st_cnt >= done_after) ? 32'h0000_0005 : 32'h0000_0002;
                        st_cnt    <= st_cnt + 1;
                    end
                    default: bus.M_din <= 32'hDEAD_BEEF;
                endcase
            end
        end
    end

    // Monitor: collects responses, bus writes and protocol violations.
    logic [128:0] obs_q[$];
    logic [128:0] exp_q[$];
    logic [39:0]  wr_log[$];
    int rsp_cnt = 0;
    int rsp_cyc = -10;
    int sel_viol = 0;
    int pulse_viol = 0;
    int poll_rd = 0;
    int hs_cnt = 0;
    logic prev_rv = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            obs_q.push_back({rsp_err, rsp_result});
            rsp_cnt++;
            rsp_cyc = cyc;
            if (prev_rv) pulse_viol++;
        end
        prev_rv = (rsp_valid === 1'b1);
        if (bus.M_sel && !bus.M_grant) sel_viol++;
        if (bus.M_sel && bus.M_wr) wr_log.push_back({bus.M_address, bus.M_dout});
        if (bus.M_sel && !bus.M_wr && bus.M_address == 8'h09) poll_rd++;
        if (cmd_valid && cmd_ready) hs_cnt++;
    end

    function automatic logic [39:0] exp_wr(input logic [63:0] a, input logic [63:0] b, input int i);
        case (i)
            0:       return {8'h08, 32'd0};
            1:       return {8'h00, a[31:0]};
            2:       return {8'h01, a[63:32]};
            3:       return {8'h02, b[31:0]};
            4:       return {8'h03, b[63:32]};
            5:       return {8'h0A, 32'd1};
            6:       return {8'h0B, 32'd1};
            7:       return {8'h0A, 32'd0};
            8:       return {8'h0B, 32'd0};
            default: return '0;
        endcase
    endfunction

    // mode 1 pushes the model product; mode 0 leaves the scoreboard to the caller.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input int mode);
        int n = 0;
        @(posedge clk); #1;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        if (mode == 1) exp_q.push_back({1'b0, {64'd0, a} * {64'd0, b}});
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output bit ok);
        int n = 0;
        while (obs_q.size() == 0 && n < limit) begin @(negedge clk); n++; end
        ok = (obs_q.size() > 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; m_interrupt = 1'b0;
        #3;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, bus.M_req, bus.M_sel, bus.M_wr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready/valid/err/req/sel/wr=%b required 000000",
                     {cmd_ready, rsp_valid, rsp_err, bus.M_req, bus.M_sel, bus.M_wr});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rsp_result, bus.M_address, bus.M_dout} !== '0) begin
            errors++;
            $display("FAIL reset_data: result=%h addr=%h dout=%h required 0", rsp_result, bus.M_address, bus.M_dout);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [128:0] o, e;
        logic [63:0] a = 64'h3, b = 64'h5;
        grant_mode = 0; done_after = 4; poll_rd = 0; wr_log.delete();
        issue(a, b, 1);
        wait_rsp(2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: no rsp_valid within 2000 cycles");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o[127:0] !== 128'hF || o[127:0] !== e[127:0]) begin
                errors++;
                $display("FAIL basic_result: got %h required %h", o[127:0], e[127:0]);
            end
            checks++;
            if (o[128] !== 1'b0) begin
                errors++;
                $display("FAIL basic_err: got %b required 0", o[128]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_log.size() != 9) begin
            errors++;
            $display("FAIL basic_wr_count: got %0d required 9", wr_log.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (wr_log[i] !== exp_wr(a, b, i)) begin
                    errors++;
                    $display("FAIL basic_wr%0d: got %h required %h", i, wr_log[i], exp_wr(a, b, i));
                end
            end
        end
        checks++;
        if (poll_rd != 6) begin
            errors++;
            $display("FAIL basic_polls: got %0d poll read cycles required 6", poll_rd);
        end
        checks++;
        if (rsp_result !== 128'hF || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: result=%h valid=%b required F and 0", rsp_result, rsp_valid);
        end
        checks++;
        if (pulse_viol != 0) begin
            errors++;
            $display("FAIL basic_pulse: rsp_valid wider than one cycle %0d times, required 0", pulse_viol);
        end
    endtask

    task automatic test_max();
        bit ok;
        logic [128:0] o, e;
        exp_q.push_back({1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001});
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        wait_rsp(2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL max_timeout: no rsp_valid within 2000 cycles");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL max_result: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_grant_toggle();
        bit ok;
        logic [128:0] o, e;
        grant_mode = 1; sel_viol = 0; wr_log.delete();
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1);
        wait_rsp(4000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL grant_timeout: no rsp_valid within 4000 cycles");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL grant_result: got %h required %h", o, e);
            end
        end
        checks++;
        if (sel_viol != 0) begin
            errors++;
            $display("FAIL grant_sel: M_sel high without grant %0d times, required 0", sel_viol);
        end
        checks++;
        if (wr_log.size() != 9) begin
            errors++;
            $display("FAIL grant_wr_count: got %0d required 9", wr_log.size());
        end
        grant_mode = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        logic [128:0] o, e;
        logic [63:0] a = 64'hAAAA_5555_0000_FFFF, b = 64'h0000_0001_0000_0002;
        done_after = 32'hFFFF_FFFF; wr_log.delete();
        exp_q.push_back({1'b1, 128'd0});
        issue(a, b, 0);
        wait_rsp(70000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tmo_timeout: no rsp_valid within 70000 cycles");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o[128] !== 1'b1) begin
                errors++;
                $display("FAIL tmo_err: got %b required 1", o[128]);
            end
            checks++;
            if (o[127:0] !== e[127:0]) begin
                errors++;
                $display("FAIL tmo_result: got %h required 0", o[127:0]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_log.size() != 9) begin
            errors++;
            $display("FAIL tmo_wr_count: got %0d required 9", wr_log.size());
        end else begin
            for (int i = 6; i < 9; i++) begin
                checks++;
                if (wr_log[i] !== exp_wr(a, b, i)) begin
                    errors++;
                    $display("FAIL tmo_wr%0d: got %h required %h", i, wr_log[i], exp_wr(a, b, i));
                end
            end
        end
        done_after = 4;
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int n = 0;
        int rc;
        logic [128:0] o, e;
        issue(64'h0000_0000_DEAD_0001, 64'h0000_0007_0000_0003, 0);
        @(negedge clk);
        while (!(bus.M_sel && !bus.M_wr && bus.M_address >= 8'h04 && bus.M_address <= 8'h07) && n < 500) begin
            @(negedge clk); n++;
        end
        checks++;
        if (!(bus.M_sel && !bus.M_wr)) begin
            errors++;
            $display("FAIL midrd_reach: read phase not seen within 500 cycles");
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, bus.M_req, bus.M_sel, bus.M_wr} !== 6'b0 ||
            {rsp_result, bus.M_address, bus.M_dout} !== '0) begin
            errors++;
            $display("FAIL midrd_outputs: ctl=%b result=%h addr=%h dout=%h required all 0",
                     {cmd_ready, rsp_valid, rsp_err, bus.M_req, bus.M_sel, bus.M_wr}, rsp_result, bus.M_address, bus.M_dout);
        end
        rc = rsp_cnt;
        wr_log.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (rsp_cnt != rc || obs_q.size() != 0 || wr_log.size() != 0 || bus.M_req !== 1'b0) begin
            errors++;
            $display("FAIL midrd_quiet: rsp=%0d writes=%0d req=%b required 0 0 0",
                     rsp_cnt - rc, wr_log.size(), bus.M_req);
        end
        issue(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0009, 1);
        wait_rsp(2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrd_next_timeout: no rsp_valid within 2000 cycles");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midrd_next_result: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n = 0;
        int hs0;
        int hc;
        logic [128:0] o, e;
        logic [63:0] a2 = 64'h0000_0000_0001_0000, b2 = 64'h0000_0000_0000_0010;
        hs0 = hs_cnt;
        issue(64'h7, 64'h9, 1);
        cmd_a = a2;
        cmd_b = b2;
        cmd_valid = 1'b1;
        exp_q.push_back({1'b0, {64'd0, a2} * {64'd0, b2}});
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
        hc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (hc != rsp_cyc + 1) begin
            errors++;
            $display("FAIL b2b_accept: handshake cycle %0d required %0d", hc, rsp_cyc + 1);
        end
        for (int k = 0; k < 2; k++) begin
            wait_rsp(2000, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_timeout%0d: no rsp_valid within 2000 cycles", k);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %h required %h", k, o, e);
                end
            end
        end
        checks++;
        if (hs_cnt - hs0 != 2) begin
            errors++;
            $display("FAIL b2b_handshakes: got %0d required 2", hs_cnt - hs0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_grant_toggle();
        test_reset_mid_read();
        test_back_to_back();
        test_timeout();
        checks++;
        if (pulse_viol != 0) begin
            errors++;
            $display("FAIL pulse_width: rsp_valid wider than one cycle %0d times, required 0", pulse_viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
